// File: rtl/traffic_pkg.sv
// Shared lamp codes and controller state encoding for the highway / farm-road
// traffic light controller.
package traffic_pkg;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    typedef enum logic [1:0] {
        HGRE_FRED = 2'd0,
        HYEL_FRED = 2'd1,
        HRED_FGRE = 2'd2,
        HRED_FYEL = 2'd3
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/traffic_light_tick_prescaler.sv
// Free-running divider: pulses tick for one clk cycle every TICK_DIV cycles.
// clr restarts the count so a new phase always begins a full tick period away.
module tick_prescaler #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        tick       = (count_reg == LAST);
        count_next = count_reg + 1'b1;
        if (clr || tick) begin
            count_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/traffic_light.sv
// Highway / farm-road intersection controller: Moore FSM with lamp decode,
// timed in prescaled ticks counted from the start of each phase.
module traffic_light
    import traffic_pkg::*;
#(
    parameter int TICK_DIV          = 1000,
    parameter int HWY_MIN_GRN_TICKS = 5,
    parameter int YEL_TICKS         = 3,
    parameter int FARM_GRN_TICKS    = 10
) (
    output logic [2:0] light_highway,
    output logic [2:0] light_farm,
    input  logic       sensor,
    input  logic       clk,
    input  logic       rst_n
);

    localparam int CNT_TOP = max_int(max_int(HWY_MIN_GRN_TICKS, YEL_TICKS), FARM_GRN_TICKS);
    localparam int CNT_W   = $clog2(CNT_TOP + 1);

    localparam logic [CNT_W-1:0] HWY_MIN  = CNT_W'(HWY_MIN_GRN_TICKS);
    localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YEL_TICKS - 1);
    localparam logic [CNT_W-1:0] FGR_LAST = CNT_W'(FARM_GRN_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] tick_cnt_reg;
    logic [CNT_W-1:0] tick_cnt_next;
    logic             tick;
    logic             state_change;

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (state_change),
        .tick (tick)
    );

    // Timed phases leave on the tick that completes their last tick period,
    // so the count compared here is the value before that tick is added.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            HGRE_FRED: begin
                if (sensor && (tick_cnt_reg >= HWY_MIN)) begin
                    state_next = HYEL_FRED;
                end
            end
            HYEL_FRED: begin
                if (tick && (tick_cnt_reg == YEL_LAST)) begin
                    state_next = HRED_FGRE;
                end
            end
            HRED_FGRE: begin
                if (tick && (tick_cnt_reg == FGR_LAST)) begin
                    state_next = HRED_FYEL;
                end
            end
            HRED_FYEL: begin
                if (tick && (tick_cnt_reg == YEL_LAST)) begin
                    state_next = HGRE_FRED;
                end
            end
            default: begin
                state_next = HGRE_FRED;
            end
        endcase
    end

    assign state_change = (state_next != state_reg);

    always_comb begin
        tick_cnt_next = tick_cnt_reg;
        if (state_change) begin
            tick_cnt_next = '0;
        end else if (tick && (tick_cnt_reg != CNT_SAT)) begin
            tick_cnt_next = tick_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= HGRE_FRED;
            tick_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            tick_cnt_reg <= tick_cnt_next;
        end
    end

    always_comb begin
        light_highway = GRN;
        light_farm    = RED;
        case (state_reg)
            HGRE_FRED: begin
                light_highway = GRN;
                light_farm    = RED;
            end
            HYEL_FRED: begin
                light_highway = YEL;
                light_farm    = RED;
            end
            HRED_FGRE: begin
                light_highway = RED;
                light_farm    = GRN;
            end
            HRED_FYEL: begin
                light_highway = RED;
                light_farm    = YEL;
            end
            default: begin
                light_highway = GRN;
                light_farm    = RED;
            end
        endcase
    end

endmodule

// File: tb/tb_traffic_light.sv
// Randomized self-checking bench for traffic_light against a cycle-count model
// of the phase timing rules (TICK_DIV reduced to 4).
module tb_traffic_light;

    localparam int TD   = 4;
    localparam int MIN  = 5;
    localparam int YT   = 3;
    localparam int FT   = 10;

    localparam logic [2:0] L_RED = 3'b100;
    localparam logic [2:0] L_YEL = 3'b010;
    localparam logic [2:0] L_GRN = 3'b001;

    logic       clk;
    logic       rst_n;
    logic       sensor;
    logic [2:0] light_highway;
    logic [2:0] light_farm;

    int n_tests;
    int n_fail;

    // Model: phase index (0 hwy green, 1 hwy yellow, 2 farm green, 3 farm yellow)
    // and clk cycles spent in that phase so far.
    int m_phase;
    int m_cyc;
    int phase_len [4];
    logic [2:0] exp_hwy  [4];
    logic [2:0] exp_farm [4];

    traffic_light #(
        .TICK_DIV(TD)
    ) dut (
        .light_highway(light_highway),
        .light_farm   (light_farm),
        .sensor       (sensor),
        .clk          (clk),
        .rst_n        (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_cyc   = 0;
    endtask

    // One rising edge of the intersection as the timing rules describe it.
    task automatic model_edge(input logic s);
        if (m_phase == 0) begin
            if (s && (m_cyc / TD) >= MIN) begin
                m_phase = 1;
                m_cyc   = 0;
            end else if (m_cyc < 1000000) begin
                m_cyc++;
            end
        end else if (m_cyc + 1 == phase_len[m_phase]) begin
            m_phase = (m_phase + 1) % 4;
            m_cyc   = 0;
        end else begin
            m_cyc++;
        end
    endtask

    task automatic check_lights();
        check("hwy", 32'(light_highway), 32'(exp_hwy[m_phase]));
        check("farm", 32'(light_farm), 32'(exp_farm[m_phase]));
        check("onehot", 32'($onehot(light_highway) && $onehot(light_farm)), 32'd1);
        check("excl", 32'(!(light_highway != L_RED && light_farm != L_RED)), 32'd1);
    endtask

    task automatic step();
        logic s;
        s = sensor;
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge(s);
        #1;
        check_lights();
    endtask

    task automatic run_until(input string tag, input bit farm_sel, input logic [2:0] want,
                             input int budget, output int n);
        n = 0;
        while (((farm_sel ? light_farm : light_highway) != want) && n < budget) begin
            step();
            n++;
        end
        if ((farm_sel ? light_farm : light_highway) != want) begin
            check({tag, "_timeout"}, 32'(farm_sel ? light_farm : light_highway), 32'(want));
        end
        $display("[TB] %s after %0d cycles", tag, n);
    endtask

    initial begin
        int n;
        int p;
        n_tests = 0;
        n_fail  = 0;
        phase_len = '{0, YT * TD, FT * TD, YT * TD};
        exp_hwy   = '{L_GRN, L_YEL, L_RED, L_RED};
        exp_farm  = '{L_RED, L_RED, L_GRN, L_YEL};
        model_reset();

        // Reset state is visible before any clock edge.
        rst_n  = 1'b0;
        sensor = 1'b0;
        #2;
        check_lights();
        step();
        step();
        rst_n = 1'b1;

        // Idle highway green with no request.
        for (int i = 0; i < 200; i++) step();
        $display("[TB] idle 200 cycles done");

        // Full request cycle with sensor held.
        sensor = 1'b1;
        run_until("hwy_yellow", 1'b0, L_YEL, 10, n);
        check("lat_yellow", 32'(n), 32'd1);
        run_until("farm_green", 1'b0, L_RED, 100, n);
        check("dur_hyel", 32'(n), 32'(YT * TD));
        run_until("farm_yellow", 1'b1, L_YEL, 200, n);
        check("dur_fgre", 32'(n), 32'(FT * TD));
        run_until("hwy_green", 1'b0, L_GRN, 100, n);
        check("dur_fyel", 32'(n), 32'(YT * TD));

        // Held sensor re-requests once the counter reaches the minimum,
        // which is first seen on the edge after the fifth tick.
        run_until("hwy_yellow_again", 1'b0, L_YEL, 200, n);
        check("dur_min_grn", 32'(n), 32'(MIN * TD + 1));

        // One-cycle pulse during farm green changes nothing.
        sensor = 1'b0;
        run_until("farm_green2", 1'b0, L_RED, 100, n);
        check("dur_hyel2", 32'(n), 32'(YT * TD));
        sensor = 1'b1;
        step();
        sensor = 1'b0;
        run_until("farm_yellow2", 1'b1, L_YEL, 200, n);
        check("dur_fgre2", 32'(n + 1), 32'(FT * TD));
        run_until("hwy_green2", 1'b0, L_GRN, 100, n);
        check("dur_fyel2", 32'(n), 32'(YT * TD));
        for (int i = 0; i < 50; i++) step();

        // Asynchronous reset in the middle of farm green.
        sensor = 1'b1;
        run_until("farm_green3", 1'b1, L_GRN, 200, n);
        for (int i = 0; i < 5; i++) step();
        #3;
        rst_n = 1'b0;
        #1;
        check("async_hwy", 32'(light_highway), 32'(L_GRN));
        check("async_farm", 32'(light_farm), 32'(L_RED));
        step();
        rst_n = 1'b1;
        run_until("hwy_yellow_post_rst", 1'b0, L_YEL, 200, n);
        check("dur_post_rst", 32'(n), 32'(MIN * TD + 1));

        // Random sensor traffic with occasional resets.
        for (int blk = 0; blk < 15; blk++) begin
            p = $urandom_range(0, 100);
            for (int i = 0; i < 200; i++) begin
                sensor = ($urandom_range(0, 99) < p);
                if ($urandom_range(0, 499) == 0) begin
                    rst_n = 1'b0;
                    step();
                    rst_n = 1'b1;
                end else begin
                    step();
                end
            end
            $display("[TB] random block %0d (p=%0d) done", blk, p);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
